// File: rtl/registro_if_id.sv
// rtl/registro_if_id.sv - IF/ID pipeline buffer: small FIFO of {pc4, instr} with field split
// Fetch may run ahead of a stalled decode stage; flush drops everything on taken branches/jumps.
module registro_if_id #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_WORD = 32'h00000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc4,
   input  logic [31:0]              in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc4,
   output logic [31:0]              out_instr,
   output logic [5:0]               opcode,
   output logic [4:0]               rs,
   output logic [4:0]               rt,
   output logic [4:0]               rd,
   output logic [4:0]               shamt,
   output logic [5:0]               funct,
   output logic [15:0]              imm,
   output logic [25:0]              target,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem_pc4   [DEPTH];
   logic [31:0]   mem_instr [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   // Handshakes depend only on registered count, so out_ready never reaches in_ready.
   assign in_ready  = (count != FULL_CNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;
   assign occupancy = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Entry storage is never cleared; count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc4[wr_ptr]   <= in_pc4;
         mem_instr[wr_ptr] <= in_instr;
      end
   end

   assign out_pc4   = out_valid ? mem_pc4[rd_ptr]   : 32'h00000000;
   assign out_instr = out_valid ? mem_instr[rd_ptr] : NOP_WORD;

   assign opcode = out_instr[31:26];
   assign rs     = out_instr[25:21];
   assign rt     = out_instr[20:16];
   assign rd     = out_instr[15:11];
   assign shamt  = out_instr[10:6];
   assign funct  = out_instr[5:0];
   assign imm    = out_instr[15:0];
   assign target = out_instr[25:0];

endmodule

// File: tb/tb_registro_if_id.sv
// tb/tb_registro_if_id.sv - scoreboard bench for registro_if_id
module tb_registro_if_id;
   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_pc4, in_instr, out_pc4, out_instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   logic [25:0] target;
   logic [$clog2(DEPTH):0] occupancy;

   entry_t sb[$];
   int total = 0;
   int bad   = 0;

   registro_if_id #(.DEPTH(DEPTH), .NOP_WORD(32'h00000000)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc4(in_pc4), .in_instr(in_instr),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4), .out_instr(out_instr),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .target(target), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle: compare visible state against the scoreboard, then clock and update it.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
      logic [31:0] ei;
      logic do_push, do_pop;
      in_valid = v; in_pc4 = pc; in_instr = ins; out_ready = ordy; flush = fl;
      #1;
      check("out_valid", out_valid, sb.size() != 0);
      check("occupancy", occupancy, sb.size());
      check("in_ready", in_ready, sb.size() < DEPTH);
      if (sb.size() != 0) begin
         ei = sb[0].instr;
         check("out_pc4", out_pc4, sb[0].pc4);
         check("out_instr", out_instr, ei);
      end else begin
         ei = 32'h00000000;
         check("empty_pc4", out_pc4, 32'h0);
         check("empty_instr", out_instr, 32'h0);
      end
      check("opcode", opcode, ei[31:26]);
      check("rs", rs, ei[25:21]);
      check("rt", rt, ei[20:16]);
      check("rd", rd, ei[15:11]);
      check("shamt", shamt, ei[10:6]);
      check("funct", funct, ei[5:0]);
      check("imm", imm, ei[15:0]);
      check("target", target, ei[25:0]);
      do_push = v && (sb.size() < DEPTH) && !fl;
      do_pop  = ordy && (sb.size() != 0);
      @(posedge clk);
      if (fl) sb.delete();
      else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back('{pc4: pc, instr: ins});
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_pc4 = 0; in_instr = 0; out_ready = 0; flush = 0;
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_occ", occupancy, 0);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // single pass with explicit field split
      step(1, 32'h4, 32'h012A4020, 1, 0);
      check("fp_valid", out_valid, 1'b1);
      check("fp_opcode", opcode, 0);
      check("fp_rs", rs, 9);
      check("fp_rt", rt, 10);
      check("fp_rd", rd, 8);
      check("fp_shamt", shamt, 0);
      check("fp_funct", funct, 32'h20);
      check("fp_imm", imm, 32'h4020);
      step(0, 0, 0, 1, 0);
      check("fp_after", out_valid, 1'b0);

      // fill and stall, then drain with the third word held
      step(1, 32'h4, $urandom, 0, 0);
      step(1, 32'h8, $urandom, 0, 0);
      check("stall_occ", occupancy, 2);
      check("stall_rdy", in_ready, 1'b0);
      begin
         logic [31:0] w3 = $urandom;
         step(1, 32'hC, w3, 0, 0);
         step(1, 32'hC, w3, 1, 0);
         step(1, 32'hC, w3, 1, 0);
         step(0, 0, 0, 1, 0);
         step(0, 0, 0, 1, 0);
      end

      // simultaneous push/pop at occupancy 1, pointers wrap
      step(1, 32'd4, $urandom, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         step(1, 32'(4 + 4 * k), $urandom, 1, 0);
         check("pp_occ", occupancy, 1);
      end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // flush at occupancy 2 with an incoming word
      step(1, 32'h100, $urandom, 0, 0);
      step(1, 32'h104, $urandom, 0, 0);
      step(1, 32'h108, $urandom, 0, 1);
      check("fl_occ", occupancy, 0);
      check("fl_valid", out_valid, 1'b0);
      step(1, 32'h200, $urandom, 0, 0);
      check("fl_first", out_pc4, 32'h200);
      step(0, 0, 0, 1, 0);

      // flush together with a pop at occupancy 1
      step(1, 32'h300, $urandom, 0, 0);
      step(0, 0, 0, 1, 1);
      check("flp_occ", occupancy, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0);

      // random traffic
      for (int k = 0; k < 60; k++)
         step(1'($urandom_range(0, 1)), $urandom, $urandom,
              1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));

      // async reset mid-cycle with two entries held
      step(1, 32'h400, $urandom, 0, 0);
      step(1, 32'h404, $urandom, 0, 0);
      in_valid = 0; out_ready = 0; flush = 0;
      #2;
      rst = 1'b1;
      #1;
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_occ", occupancy, 0);
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_instr", out_instr, 32'h0);
      sb.delete();
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      step(1, 32'h500, $urandom, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
